// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM,
// single-cycle valid / framing-error strobes and a break hold state.
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       i_reset,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_framing_error,
  output logic       o_busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic             rx_meta_q;
  logic             rx_s_q;

  // Both flops reset to the idle-high level so release never looks like a start edge.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep the two stages distinct flops;
      // blocking here would collapse the synchronizer into a single stage.
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      idx_q           <= '0;
      shift_q         <= '0;
      o_data          <= '0;
      o_valid         <= 1'b0;
      o_framing_error <= 1'b0;
    end else begin
      o_valid         <= 1'b0;
      o_framing_error <= 1'b0;
      cnt_q           <= cnt_q + 1'b1;

      unique case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!rx_s_q) begin
            state_q <= S_START;
          end
        end

        // Re-check the line at mid start bit so short low glitches are dropped.
        S_START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q <= '0;
            if (!rx_s_q) begin
              state_q <= S_DATA;
              idx_q   <= '0;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end

        S_DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_s_q;
            if (idx_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end

        S_STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              o_data  <= shift_q;
              o_valid <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              o_framing_error <= 1'b1;
              state_q         <= S_BREAK;
            end
          end
        end

        // A line held low after a bad stop bit must not decode as new frames.
        S_BREAK: begin
          cnt_q <= '0;
          if (rx_s_q) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: frames are driven bit by bit, expected
// strobes are queued with their due cycle, and a monitor checks every strobe.
module tb_uart_receiver;

  localparam int CPB = 16;
  // i_rx driven on a falling edge is captured on the next rising edge (clock 0);
  // the strobe is registered 154 rising edges later and observed on the
  // falling edge after that.
  localparam longint LATENCY = 2 + CPB / 2 + 9 * CPB + 1;

  logic       clk;
  logic       i_reset;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_framing_error;
  logic       o_busy;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk             (clk),
    .i_reset         (i_reset),
    .i_rx            (i_rx),
    .o_data          (o_data),
    .o_valid         (o_valid),
    .o_framing_error (o_framing_error),
    .o_busy          (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         ferr;
    longint     due;
  } exp_t;

  exp_t       exp_q[$];
  longint     cyc;
  int         n_tests;
  int         n_fail;
  logic [7:0] last_good;
  longint     strobe_t;
  longint     prev_strobe_t;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard in kind, data and time.
  always @(negedge clk) begin
    if (i_reset) begin
      if (o_valid || o_framing_error) begin
        prev_strobe_t = strobe_t;
        strobe_t      = cyc;
        check(!(o_valid && o_framing_error), "strobe_exclusive", {o_valid, o_framing_error}, 2'b10);
        check(exp_q.size() != 0, "unexpected_strobe", o_data, 0);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check(o_valid == !e.ferr, "strobe_kind", {o_valid, o_framing_error}, {!e.ferr, e.ferr});
          check(o_data == e.data, "strobe_data", o_data, e.data);
          check(cyc == e.due, "strobe_time", cyc, e.due);
        end
      end
      if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
        check(1'b0, "missing_strobe", cyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a falling edge; returns on the falling edge ending the stop bit.
  task automatic send_frame(input logic [7:0] b, input bit stop);
    exp_t e;
    i_rx   = 1'b0;
    e.ferr = !stop;
    e.due  = cyc + LATENCY;
    if (stop) last_good = b;
    e.data = last_good;
    exp_q.push_back(e);
    idle(CPB);
    for (int k = 0; k < 8; k++) begin
      i_rx = b[k];
      idle(CPB);
    end
    i_rx = stop;
    idle(CPB);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    check(exp_q.size() == 0, "drain", exp_q.size(), 0);
  endtask

  initial begin
    cyc           = 0;
    n_tests       = 0;
    n_fail        = 0;
    last_good     = 8'h00;
    strobe_t      = 0;
    prev_strobe_t = 0;
    i_rx          = 1'b1;
    i_reset       = 1'b0;

    // Reset then idle
    idle(10);
    check({o_data, o_valid, o_framing_error, o_busy} == 11'd0, "reset_outputs",
          {o_data, o_valid, o_framing_error, o_busy}, 0);
    i_reset = 1'b1;
    idle(200);
    check(o_data == 8'h00, "idle_data", o_data, 8'h00);
    check(o_busy == 1'b0, "idle_busy", o_busy, 0);

    // Single frame with latency check in the monitor
    send_frame(8'hA5, 1'b1);
    idle(5);
    drain();
    check(o_data == 8'hA5, "a5_data", o_data, 8'hA5);

    // Glitch shorter than half a bit
    i_rx = 1'b0;
    idle(3);
    check(o_busy == 1'b1, "glitch_busy_rise", o_busy, 1);
    i_rx = 1'b1;
    idle(20);
    check(o_busy == 1'b0, "glitch_busy_fall", o_busy, 0);
    check(o_data == 8'hA5, "glitch_data", o_data, 8'hA5);

    // Framing error followed by a held-low line
    send_frame(8'h3C, 1'b1);
    send_frame(8'h00, 1'b0);
    idle(40);
    check(o_busy == 1'b1, "break_busy", o_busy, 1);
    i_rx = 1'b1;
    idle(10);
    drain();
    check(o_data == 8'h3C, "ferr_data_kept", o_data, 8'h3C);
    check(o_busy == 1'b0, "break_released", o_busy, 0);

    // Back-to-back with minimal spacing
    send_frame(8'h0F, 1'b1);
    send_frame(8'hF0, 1'b1);
    idle(5);
    drain();
    check(strobe_t - prev_strobe_t == 160, "b2b_spacing", strobe_t - prev_strobe_t, 160);
    check(o_data == 8'hF0, "b2b_data", o_data, 8'hF0);

    // Randomized frames with occasional bad stop bits
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      bit         bad;
      int         gap;
      b   = 8'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      gap = $urandom_range(0, 12);
      send_frame(b, !bad);
      i_rx = 1'b1;
      if (bad) gap += CPB;
      idle(gap);
    end
    idle(5);
    drain();
    check(o_data == last_good, "random_last_data", o_data, last_good);

    // Reset in the middle of data bit 3 of 0xFF
    i_rx = 1'b0;
    idle(CPB);
    i_rx = 1'b1;
    idle(3 * CPB + CPB / 2);
    check(o_busy == 1'b1, "midframe_busy", o_busy, 1);
    i_reset = 1'b0;
    #1;
    check({o_data, o_valid, o_framing_error, o_busy} == 11'd0, "midframe_reset_clear",
          {o_data, o_valid, o_framing_error, o_busy}, 0);
    last_good = 8'h00;
    idle(5);
    i_reset = 1'b1;
    idle(20);
    check(o_busy == 1'b0, "post_reset_idle", o_busy, 0);
    send_frame(8'h81, 1'b1);
    idle(5);
    drain();
    check(o_data == 8'h81, "post_reset_data", o_data, 8'h81);

    // Transmitter-style loopback byte
    idle(7);
    send_frame(8'hF0, 1'b1);
    idle(5);
    drain();
    check(o_data == 8'hF0, "loopback_data", o_data, 8'hF0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
